// File: rtl/instruction_fetch_unit.sv
// Sequential MIPS fetch front end: owns the PC, fetches over a ready handshake,
// and presents one instruction at a time, backed by a one-entry prefetch buffer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        Jump,
  input  logic        Zero
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} fetchState_t;

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] pfData;
  logic        pfValid;

  logic        accept;
  logic        taken;
  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;
  logic [31:0] target;
  logic [31:0] nextSeqPc;

  always_comb begin
    accept       = instr_valid & instr_ack;
    taken        = Jump | (BranchEQ & Zero) | (BranchNE & ~Zero);
    jumpTarget   = {pc_plus4[31:28], instr[25:0], 2'b00};
    branchTarget = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    target       = Jump ? jumpTarget : branchTarget;
    nextSeqPc    = pc_plus4 + 32'd4;
  end

  // imem_req/imem_addr are registered alongside the state so a request, once
  // raised, holds its address until imem_ready without any combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pfValid     <= 1'b0;
      pfData      <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
      pc_plus4    <= RESET_PC + 32'd4;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        FETCH: begin
          if (imem_ready) begin
            state       <= ISSUE;
            instr_valid <= 1'b1;
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc_plus4    <= pc + 32'd4;
            imem_addr   <= pc + 32'd4;
          end
        end
        ISSUE: begin
          if (accept) begin
            pfValid <= 1'b0;
            if (taken) begin
              pc          <= target;
              instr_valid <= 1'b0;
              // An unanswered prefetch must complete before the target fetch.
              if (!pfValid && !imem_ready) begin
                state <= DRAIN;
              end else begin
                state     <= FETCH;
                imem_req  <= 1'b1;
                imem_addr <= target;
              end
            end else if (pfValid || imem_ready) begin
              instr     <= pfValid ? pfData : imem_rdata;
              instr_pc  <= pc_plus4;
              pc_plus4  <= nextSeqPc;
              pc        <= pc_plus4;
              imem_req  <= 1'b1;
              imem_addr <= nextSeqPc;
            end else begin
              // Outstanding prefetch already targets pc_plus4; FETCH adopts it.
              state       <= FETCH;
              instr_valid <= 1'b0;
              pc          <= pc_plus4;
            end
          end else if (!pfValid && imem_ready) begin
            pfValid  <= 1'b1;
            pfData   <= imem_rdata;
            imem_req <= 1'b0;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state     <= FETCH;
            imem_addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of instruction_fetch_unit against an
// architectural next-PC model and a wait-state memory responder.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack;
  logic        BranchEQ;
  logic        BranchNE;
  logic        Jump;
  logic        Zero;

  logic        req2;
  logic [31:0] addr2;
  logic        ready2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] p4_2;
  logic        valid2;
  logic        ack2;
  logic        ctl2;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ack(instr_ack),
    .BranchEQ(BranchEQ), .BranchNE(BranchNE), .Jump(Jump), .Zero(Zero)
  );

  // Second instance starts just below 2^32 to exercise PC wrap-around.
  instruction_fetch_unit #(.RESET_PC(WRAP_PC)) dutWrap (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_rdata(rdata2),
    .instr(instr2), .instr_pc(pc2), .pc_plus4(p4_2),
    .instr_valid(valid2), .instr_ack(ack2),
    .BranchEQ(ctl2), .BranchNE(ctl2), .Jump(ctl2), .Zero(ctl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] memOv [logic [31:0]];

  // Knobs
  int unsigned waitMax   = 0;
  bit          waitFixed = 0;
  int unsigned ackPct    = 100;
  bit          ctlForce  = 1;
  logic [31:0] ctlPc     = '0;
  logic [3:0]  ctlVal    = '0;   // {Jump, BranchEQ, BranchNE, Zero}

  // Memory responder and reference model state
  bit          reqPending  = 0;
  logic [31:0] pendAddr    = '0;
  int unsigned waitLeft    = 0;
  bit          readyDriven = 0;
  logic [31:0] expPc       = RESET_PC;
  bit          holdPrev    = 0;
  logic [31:0] holdInstr   = '0;
  logic [31:0] holdPc      = '0;
  bit          lastAcc     = 0;
  logic [31:0] lastAccPc   = '0;
  int          accCount    = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (memOv.exists(a)) return memOv[a];
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [31:0] w;
    logic [31:0] p4;
    int          off;
    @(negedge clk);
    if (holdPrev) begin
      check("holdValid", {31'b0, instr_valid}, 32'd1);
      check("holdInstr", instr, holdInstr);
      check("holdPc", instr_pc, holdPc);
    end
    if (reqPending) begin
      check("reqHold", {31'b0, imem_req}, 32'd1);
      check("addrHold", imem_addr, pendAddr);
    end else if (imem_req) begin
      reqPending = 1;
      pendAddr   = imem_addr;
      waitLeft   = waitFixed ? waitMax : $urandom_range(0, waitMax);
      check("addrAlign", {30'b0, imem_addr[1:0]}, 32'd0);
    end
    readyDriven = 0;
    if (reqPending && waitLeft == 0) begin
      imem_ready  = 1'b1;
      imem_rdata  = memWord(pendAddr);
      reqPending  = 0;
      readyDriven = 1;
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom();
      if (reqPending) waitLeft--;
    end
    instr_ack = ($urandom_range(0, 99) < ackPct);
    if (ctlForce && instr_valid && instr_ack)
      {Jump, BranchEQ, BranchNE, Zero} = (instr_pc == ctlPc) ? ctlVal : 4'b0000;
    else if (ctlForce)
      {Jump, BranchEQ, BranchNE, Zero} = 4'($urandom());
    else begin
      Jump     = ($urandom_range(0, 11) == 0);
      BranchEQ = ($urandom_range(0, 5) == 0);
      BranchNE = ($urandom_range(0, 5) == 0);
      Zero     = $urandom_range(0, 1) == 1;
    end
    lastAcc = instr_valid && instr_ack;
    if (lastAcc) begin
      w = memWord(expPc);
      p4 = expPc + 32'd4;
      check("accPc", instr_pc, expPc);
      check("accInstr", instr, w);
      check("accPc4", pc_plus4, p4);
      lastAccPc = instr_pc;
      accCount++;
      if (Jump) expPc = (p4 & 32'hF000_0000) | {4'b0, w[25:0], 2'b00};
      else if ((BranchEQ && Zero) || (BranchNE && !Zero)) begin
        off = $signed(w[15:0]);
        expPc = p4 + 32'(off * 4);
      end else expPc = p4;
    end
    holdPrev  = instr_valid && !instr_ack;
    holdInstr = instr;
    holdPc    = instr_pc;
  endtask

  task automatic doReset();
    #2;
    reset      = 1'b1;
    imem_ready = 1'b0;
    instr_ack  = 1'b0;
    {Jump, BranchEQ, BranchNE, Zero} = 4'b0000;
    #1;
    check("rstReq", {31'b0, imem_req}, 32'd0);
    check("rstAddr", imem_addr, RESET_PC);
    check("rstInstr", instr, 32'd0);
    check("rstValid", {31'b0, instr_valid}, 32'd0);
    check("rstInstrPc", instr_pc, RESET_PC);
    check("rstPc4", pc_plus4, RESET_PC + 32'd4);
    check("rstWrapPc4", p4_2, 32'hFFFF_FFFC);
    reqPending = 0;
    holdPrev   = 0;
    lastAcc    = 0;
    expPc      = RESET_PC;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runUntilAcc(input string tag, input logic [31:0] pc, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      found = lastAcc && (lastAccPc == pc);
    end
    check(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic nextAcc(input string tag, input logic [31:0] want, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      found = lastAcc;
    end
    check({tag, "Seen"}, {31'b0, found}, 32'd1);
    check(tag, lastAccPc, want);
  endtask

  initial begin
    int drainSteps;
    int startAcc;
    bit found;
    ready2 = 1'b1;
    rdata2 = '0;
    ack2   = 1'b1;
    ctl2   = 1'b0;
    imem_rdata = '0;
    memOv[32'h0040_0010] = {6'h04, 10'h000, 16'hFFFC};
    memOv[32'h0040_0020] = {6'h02, 26'h010_0008};
    memOv[32'h0040_0024] = {6'h05, 10'h000, 16'h0010};

    doReset();

    step();
    check("c1Req", {31'b0, imem_req}, 32'd1);
    check("c1Addr", imem_addr, 32'h0040_0000);
    check("c1Valid", {31'b0, instr_valid}, 32'd0);
    check("wrapC1Addr", addr2, WRAP_PC);
    step();
    check("c2Valid", {31'b0, instr_valid}, 32'd1);
    check("c2Pc", instr_pc, 32'h0040_0000);
    check("c2Addr", imem_addr, 32'h0040_0004);
    check("wrapC2Valid", {31'b0, valid2}, 32'd1);
    check("wrapC2Pc", pc2, WRAP_PC);
    check("wrapC2Instr", instr2, 32'd0);
    check("wrapC2Addr", addr2, 32'hFFFF_FFFC);
    step();
    check("c3Valid", {31'b0, instr_valid}, 32'd1);
    check("c3Pc", instr_pc, 32'h0040_0004);
    check("c3Addr", imem_addr, 32'h0040_0008);
    check("wrapC3Pc", pc2, 32'hFFFF_FFFC);
    check("wrapC3Pc4", p4_2, 32'd0);
    check("wrapC3Addr", addr2, 32'd0);

    // Stall decode for five cycles while the prefetch lands in the buffer.
    ackPct = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) check("wrapC4Pc", pc2, 32'd0);
      if (i > 0) check("pfFullNoReq", {31'b0, imem_req}, 32'd0);
    end
    check("stallPc", instr_pc, 32'h0040_0008);
    ackPct = 100;
    step();
    step();
    check("noBubbleValid", {31'b0, instr_valid}, 32'd1);
    check("noBubblePc", instr_pc, 32'h0040_000C);

    ctlPc = 32'h0040_0010; ctlVal = 4'b0101;
    runUntilAcc("reachBeqT", 32'h0040_0010, 50);
    nextAcc("beqTaken", 32'h0040_0004, 50);
    ctlVal = 4'b0100;
    runUntilAcc("reachBeqN", 32'h0040_0010, 50);
    nextAcc("beqNotTaken", 32'h0040_0014, 50);
    ctlPc = 32'h0040_0020; ctlVal = 4'b1101;
    runUntilAcc("reachJump", 32'h0040_0020, 50);
    nextAcc("jumpOverBeq", 32'h0040_0020, 50);
    ctlPc = 32'h0040_0024; ctlVal = 4'b0010;
    runUntilAcc("reachBne", 32'h0040_0024, 50);
    nextAcc("bneTaken", 32'h0040_0068, 50);

    // Three wait states: a taken branch leaves the prefetch outstanding.
    doReset();
    waitFixed = 1; waitMax = 3;
    ctlPc = 32'h0040_0010; ctlVal = 4'b0101;
    runUntilAcc("reachBeqWait", 32'h0040_0010, 200);
    check("drainPending", {31'b0, readyDriven}, 32'd0);
    drainSteps = 0;
    do begin
      step();
      drainSteps++;
      check("drainNoValid", {31'b0, instr_valid}, 32'd0);
    end while (!readyDriven && drainSteps < 10);
    check("drainLen", 32'(drainSteps), 32'd3);
    step();
    check("drainNextReq", {31'b0, imem_req}, 32'd1);
    check("drainNextAddr", imem_addr, 32'h0040_0004);
    nextAcc("drainTarget", 32'h0040_0004, 50);

    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = imem_req && !instr_valid;
    end
    check("reachFetch", {31'b0, found}, 32'd1);
    doReset();
    step();
    check("restartReq", {31'b0, imem_req}, 32'd1);
    check("restartAddr", imem_addr, RESET_PC);
    nextAcc("restartPc", RESET_PC, 50);

    waitFixed = 0; waitMax = 2; ackPct = 70; ctlForce = 0;
    startAcc = accCount;
    repeat (3000) step();
    check("randomProgress", {31'b0, (accCount - startAcc) > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
